param_updown_counter: RTL and testbench



---
 rtl/param_updown_counter_if.sv | 27 ++
 rtl/param_updown_counter.sv | 88 ++++++++
 tb/tb_param_updown_counter.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/param_updown_counter_if.sv
// Control/status bundle for param_updown_counter: the master drives the controls,
// the counter (slave) returns count and status.
interface param_updown_counter_if #(
  parameter int WIDTH = 4
);
  logic             en;
  logic             up;
  logic             clr;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             sat_mode;
  logic             ovf_clr;
  logic [WIDTH-1:0] count;
  logic             tc;
  logic             wrap;
  logic             ovf_sticky;

  modport master (
    output en, up, clr, load, load_val, sat_mode, ovf_clr,
    input  count, tc, wrap, ovf_sticky
  );

  modport slave (
    input  en, up, clr, load, load_val, sat_mode, ovf_clr,
    output count, tc, wrap, ovf_sticky
  );
endinterface

// File: rtl/param_updown_counter.sv
// WIDTH-bit up/down counter over 0..MAX_VAL with clear, clamped load, wrap or
// saturate at the range ends, and wrap-pulse / sticky-overflow status.
module param_updown_counter #(
  parameter int WIDTH   = 4,
  parameter int MAX_VAL = 2**WIDTH - 1,
  parameter int RST_VAL = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  param_updown_counter_if.slave bus
);
  localparam logic [WIDTH:0]   MAX_EXT = (WIDTH+1)'(MAX_VAL);
  localparam logic [WIDTH-1:0] MAX_W   = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] RST_W   = WIDTH'(RST_VAL);

  logic [WIDTH-1:0] r_count;
  logic             r_wrap;
  logic             r_ovf;

  logic             w_tc;
  logic             w_boundary;
  logic [WIDTH:0]   w_inc;
  logic [WIDTH:0]   w_dec;
  logic [WIDTH-1:0] w_load_clamped;
  logic [WIDTH-1:0] w_count_next;
  logic             w_wrap_next;
  logic             w_ovf_next;

  assign w_tc       = bus.up ? (r_count == MAX_W) : (r_count == '0);
  assign w_boundary = bus.en && w_tc && !bus.clr && !bus.load;

  // One spare bit so range ends are detected against MAX_VAL, not 2**WIDTH.
  assign w_inc = {1'b0, r_count} + (WIDTH+1)'(1);
  assign w_dec = {1'b0, r_count} - (WIDTH+1)'(1);

  assign w_load_clamped = ({1'b0, bus.load_val} > MAX_EXT) ? MAX_W : bus.load_val;

  always_comb begin
    w_count_next = r_count;
    if (bus.clr) begin
      w_count_next = '0;
    end else if (bus.load) begin
      w_count_next = w_load_clamped;
    end else if (bus.en) begin
      if (bus.up) begin
        if (w_inc > MAX_EXT) begin
          w_count_next = bus.sat_mode ? MAX_W : '0;
        end else begin
          w_count_next = w_inc[WIDTH-1:0];
        end
      end else begin
        if (w_dec[WIDTH]) begin
          w_count_next = bus.sat_mode ? '0 : MAX_W;
        end else begin
          w_count_next = w_dec[WIDTH-1:0];
        end
      end
    end
  end

  always_comb begin
    w_wrap_next = w_boundary && !bus.sat_mode;
    w_ovf_next  = r_ovf;
    // A boundary event on the same edge as a clear keeps the flag set.
    if (w_boundary) begin
      w_ovf_next = 1'b1;
    end else if (bus.ovf_clr || bus.clr) begin
      w_ovf_next = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= RST_W;
      r_wrap  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_count <= w_count_next;
      r_wrap  <= w_wrap_next;
      r_ovf   <= w_ovf_next;
    end
  end

  assign bus.count      = r_count;
  assign bus.tc         = w_tc;
  assign bus.wrap       = r_wrap;
  assign bus.ovf_sticky = r_ovf;
endmodule

// File: tb/tb_param_updown_counter.sv
// Directed bench: a full-range 4-bit counter for free-run/reset, and a
// modulo-10 counter for wrap, saturation, priority and sticky-flag cases.
module tb_param_updown_counter;
  logic clk;
  logic rst_a;
  logic rst_b;
  int   n_assert;
  int   n_fail;

  param_updown_counter_if #(.WIDTH(4)) ia ();
  param_updown_counter_if #(.WIDTH(4)) ib ();

  param_updown_counter #(.WIDTH(4), .MAX_VAL(15), .RST_VAL(0)) u_dut_a (
    .clk (clk),
    .rst (rst_a),
    .bus (ia.slave)
  );

  param_updown_counter #(.WIDTH(4), .MAX_VAL(9), .RST_VAL(0)) u_dut_b (
    .clk (clk),
    .rst (rst_b),
    .bus (ib.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       en;
    logic       up;
    logic       clr;
    logic       load;
    logic [3:0] lv;
    logic       sat;
    logic       oc;
    logic [3:0] e_count;
    logic       e_tc;
    logic       e_wrap;
    logic       e_ovf;
  } vec_t;

  vec_t vt[16];

  task automatic chk(input string name, input int act, input int exp);
    n_assert++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_b(input string name, input int e_count, input int e_tc,
                       input int e_wrap, input int e_ovf);
    chk({name, ".count"}, int'(ib.count), e_count);
    chk({name, ".tc"}, int'(ib.tc), e_tc);
    chk({name, ".wrap"}, int'(ib.wrap), e_wrap);
    chk({name, ".ovf"}, int'(ib.ovf_sticky), e_ovf);
    $display("%s: count=%0d tc=%0d wrap=%0d ovf=%0d", name, ib.count, ib.tc,
             ib.wrap, ib.ovf_sticky);
  endtask

  task automatic drive_b(input logic en, input logic up, input logic clr, input logic load,
                         input logic [3:0] lv, input logic sat, input logic oc);
    ib.en = en; ib.up = up; ib.clr = clr; ib.load = load;
    ib.load_val = lv; ib.sat_mode = sat; ib.ovf_clr = oc;
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    rst_a = 1'b0;
    rst_b = 1'b0;
    ia.en = 1'b0; ia.up = 1'b1; ia.clr = 1'b0; ia.load = 1'b0;
    ia.load_val = '0; ia.sat_mode = 1'b0; ia.ovf_clr = 1'b0;
    drive_b(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);

    // Priority, clamp, hold and sticky-clear cases; starts at count=9, wrap=1, ovf=1.
    vt[0]  = '{"clr_clears",      1, 1, 1, 0, 4'd0,  0, 0, 4'd0, 0, 0, 0};
    vt[1]  = '{"sat_dn_hit",      1, 0, 0, 0, 4'd0,  1, 0, 4'd0, 1, 0, 1};
    vt[2]  = '{"ovf_clr_alone",   0, 0, 0, 0, 4'd0,  1, 1, 4'd0, 1, 0, 0};
    vt[3]  = '{"clr_over_load",   1, 1, 1, 1, 4'd5,  0, 0, 4'd0, 0, 0, 0};
    vt[4]  = '{"load_clamp15",    0, 1, 0, 1, 4'd15, 0, 0, 4'd9, 1, 0, 0};
    vt[5]  = '{"load_over_en",    1, 1, 0, 1, 4'd5,  0, 0, 4'd5, 0, 0, 0};
    vt[6]  = '{"load_clamp10",    0, 1, 0, 1, 4'd10, 0, 0, 4'd9, 1, 0, 0};
    vt[7]  = '{"load7",           0, 1, 0, 1, 4'd7,  0, 0, 4'd7, 0, 0, 0};
    vt[8]  = '{"hold1",           0, 1, 0, 0, 4'd0,  0, 0, 4'd7, 0, 0, 0};
    vt[9]  = '{"hold2",           0, 1, 0, 0, 4'd0,  0, 0, 4'd7, 0, 0, 0};
    vt[10] = '{"hold3",           0, 1, 0, 0, 4'd0,  0, 0, 4'd7, 0, 0, 0};
    vt[11] = '{"hold4",           0, 1, 0, 0, 4'd0,  0, 0, 4'd7, 0, 0, 0};
    vt[12] = '{"hold5",           0, 1, 0, 0, 4'd0,  0, 0, 4'd7, 0, 0, 0};
    vt[13] = '{"load9",           0, 1, 0, 1, 4'd9,  0, 0, 4'd9, 1, 0, 0};
    vt[14] = '{"set_beats_clr",   1, 1, 0, 0, 4'd0,  1, 1, 4'd9, 1, 0, 1};
    vt[15] = '{"ovf_clr_next",    0, 1, 0, 0, 4'd0,  1, 1, 4'd9, 1, 0, 0};

    // Asynchronous reset holds both counters at RST_VAL before any edge.
    #3;
    chk("a_rst.count", int'(ia.count), 0);
    chk("a_rst.wrap", int'(ia.wrap), 0);
    chk("a_rst.ovf", int'(ia.ovf_sticky), 0);
    chk("b_rst.count", int'(ib.count), 0);
    $display("reset: a.count=%0d b.count=%0d", ia.count, ib.count);

    @(negedge clk);
    rst_a = 1'b1;
    ia.en = 1'b1;
    ia.up = 1'b1;
    for (int i = 1; i <= 17; i++) begin
      @(posedge clk); #1;
      chk($sformatf("a_run%0d.count", i), int'(ia.count), i % 16);
      chk($sformatf("a_run%0d.wrap", i), int'(ia.wrap), (i == 16) ? 1 : 0);
      chk($sformatf("a_run%0d.ovf", i), int'(ia.ovf_sticky), (i >= 16) ? 1 : 0);
      chk($sformatf("a_run%0d.tc", i), int'(ia.tc), (i == 15) ? 1 : 0);
      $display("a_run%0d: count=%0d wrap=%0d ovf=%0d", i, ia.count, ia.wrap, ia.ovf_sticky);
    end
    #2;
    rst_a = 1'b0;
    #1;
    chk("a_midrst.count", int'(ia.count), 0);
    chk("a_midrst.wrap", int'(ia.wrap), 0);
    chk("a_midrst.ovf", int'(ia.ovf_sticky), 0);
    $display("a_midrst: count=%0d ovf=%0d", ia.count, ia.ovf_sticky);

    // Modulo-10: count up to the terminal value, wrap up, then wrap down.
    @(negedge clk);
    rst_b = 1'b1;
    drive_b(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    for (int i = 1; i <= 9; i++) begin
      @(posedge clk); #1;
      chk_b($sformatf("b_up%0d", i), i, (i == 9) ? 1 : 0, 0, 0);
    end
    @(posedge clk); #1;
    chk_b("b_wrap_up", 0, 0, 1, 1);
    ib.up = 1'b0;
    @(posedge clk); #1;
    chk_b("b_wrap_dn", 9, 0, 1, 1);

    for (int k = 0; k < 16; k++) begin
      drive_b(vt[k].en, vt[k].up, vt[k].clr, vt[k].load, vt[k].lv, vt[k].sat, vt[k].oc);
      @(posedge clk); #1;
      chk_b(vt[k].name, int'(vt[k].e_count), int'(vt[k].e_tc),
            int'(vt[k].e_wrap), int'(vt[k].e_ovf));
    end

    // Saturating run from 9: hold at the top, then descend and hold at 0.
    drive_b(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk); #1;
      chk_b($sformatf("b_sat_up%0d", i), 9, 1, 0, 1);
    end
    ib.up = 1'b0;
    for (int i = 1; i <= 11; i++) begin
      @(posedge clk); #1;
      chk_b($sformatf("b_sat_dn%0d", i), (i < 9) ? 9 - i : 0, (i >= 9) ? 1 : 0, 0, 1);
    end

    // tc follows up combinationally without an edge.
    ib.en = 1'b0;
    ib.up = 1'b1;
    #1;
    chk("b_tc_dir", int'(ib.tc), 0);
    $display("b_tc_dir: count=%0d tc=%0d", ib.count, ib.tc);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
